uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

UART transmitter that serialises one 8-bit byte per request into a standard asynchronous frame: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. It sits directly downstream of the baud generator and consumes its `baud_clk` output as a bit-rate reference. The block runs entirely on the 50 MHz system clock, and bit timing is derived from rising edges of `baud_clk`. Its `tx_out` drives the serial line.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame. Only 8 is supported.

Ports:
- `clock`  in  1  system clock (50 MHz), shared with the baud generator.
- `reset`  in  1  asynchronous, active-high reset.
- `baud_clk`  in  1  bit-rate reference from the baud generator, synchronous to `clock`. Each rising edge is one bit tick.
- `data_in`  in  8  byte to transmit, sampled on acceptance.
- `send`  in  1  transmit request.
- `stop2`  in  1  0 selects 1 stop bit, 1 selects 2 stop bits. Sampled on acceptance.
- `parity_odd`  in  1  0 selects even parity, 1 selects odd parity. Sampled on acceptance. Ignored when parity is compiled out.
- `ready`  out  1  high when in IDLE and able to accept a request.
- `busy`  out  1  high from the cycle after acceptance until the return to IDLE.
- `done`  out  1  one-cycle pulse on the first cycle back in IDLE after the final stop bit.
- `tx_out`  out  1  serial line, registered, idles high.

## Operation
- **Tick:** `tick = baud_clk & ~baud_prev`.
  - `baud_prev` is registered every cycle and resets to 0.
  - No synchroniser is used, because `baud_clk` is already registered in the `clock` domain.
- **Acceptance:** a request is accepted when `send && ready`.
  - On acceptance, `data_in`, `stop2` and `parity_odd` are latched into a shift register and config flops.
  - `send` while busy is ignored; no queueing.
  - Changes to `data_in` after acceptance have no effect on the frame in flight.
- **FSM states:** IDLE, ARM, START, DATA, PARITY, STOP. All transitions except IDLE→ARM and STOP→IDLE happen only on `tick`.
  - IDLE: `tx_out`=1. Goes to ARM on acceptance. A tick arriving in IDLE is ignored, including a tick coincident with acceptance.
  - ARM: `tx_out`=1. Goes to START on tick. This aligns the start bit to a full bit period.
  - START: `tx_out`=0. Goes to DATA on tick, with bit counter = 0.
  - DATA: `tx_out` = shift register bit 0. On each tick, shift right and increment the counter. After bit 7's period ends, go to PARITY, or to STOP when parity is compiled out.
  - PARITY: `tx_out` = (XOR of the 8 data bits) XOR `parity_odd`. Goes to STOP on tick.
  - STOP: `tx_out`=1. With `stop2`=0, goes to IDLE after one tick. With `stop2`=1, goes to IDLE after two ticks.
- **Outputs:**
  - `done` pulses on the STOP→IDLE cycle, as the first IDLE cycle.
  - `ready` = (state==IDLE).
  - A new `send` is accepted in the same cycle that `done` is high (back-to-back frames).
- **Bit counter:** 3 bits; wraps 7→0 on the transition out of DATA.
- **Reset mid-frame:** asynchronous return to IDLE. `tx_out`=1 immediately, and the frame is aborted; no `done`.

## Timing
- **Reset values:** `tx_out`=1, `ready`=1, `busy`=0, `done`=0, state=IDLE, `baud_prev`=0, shift register=0.
- **Ticks:** ticks occur once per `baud_clk` period. With the baud generator's `final_value` F, that period is 2·(F+1) clocks.
- **Start-bit latency:** the start bit appears on `tx_out` one clock after the first tick following acceptance. This tick comes one full bit period or less after acceptance.
- **Bit changes:** every bit change on `tx_out` occurs exactly one clock after a tick (registered output).
- **Frame length:** in ticks after ARM, the frame lasts 1 + 8 + P + S bit periods, where P ∈ {0,1} and S ∈ {1,2}.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- **Defined:** the PARITY state is present, and the parity bit is sent per `parity_odd`. The frame is 11 or 12 bits.
- **Undefined:** the PARITY state and the parity XOR are not built, and DATA goes directly to STOP. The `parity_odd` port remains present but unused. The frame is 10 or 11 bits.

## Structure
- **Package `uart_pkg`:**
  - `tx_state_t` enum: IDLE, ARM, START, DATA, PARITY, STOP.
  - `UART_DATA_BITS`=8.
  - Parity encoding constants PARITY_EVEN=1'b0 and PARITY_ODD=1'b1.
- **Sub-module `uart_tick_detect`:**
  - Rising-edge detector on `baud_clk` with asynchronous active-high reset, producing `tick`.
  - Reusable by the future receiver.

## Test plan
All scenarios use a bench-driven `baud_clk` with a period of 8 clocks.
- Reset asserted mid-DATA, at bit 3 → `tx_out`=1 in the same cycle, `ready`=1, no `done`. The next `send` of 0x00 produces a clean full frame.
- `send` with 0xA5, `stop2`=0, parity compiled out → `tx_out` sequence 1(ARM),0,1,0,1,0,0,1,0,1,1, each bit held 8 clocks. `done` pulses once, and `busy` is low afterwards.
- `UART_TX_PARITY_EN` defined, 0xA5 with `parity_odd`=0 → parity bit 0. Same byte with `parity_odd`=1 → parity bit 1. 0x01 with even parity → parity bit 1.
- `stop2`=1 with 0xFF → the stop level is held for 16 clocks before `done`. `send` asserted in the `done` cycle with 0x3C is accepted, and the second frame starts on the next tick.
- `send` pulsed during DATA with 0x00 → ignored. The frame in flight is unchanged, and exactly one `done` is seen.
- `send` coincident with a tick while in IDLE → ARM is entered. The start bit begins one clock after the next tick, 8 clocks later, not immediately.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit/receive
//               blocks: frame state encoding, data width and parity encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Parity selection as carried on parity_odd
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tick_detect.sv
`default_nettype none
// ============================================================================
// Module      : uart_tick_detect
// Description : Rising-edge detector for the baud reference. baud_clk is
//               already a register output in the clock domain, so no
//               synchroniser is placed in front of it.
// Ports       : clock    in  system clock
//               reset    in  asynchronous active-high reset
//               baud_clk in  bit-rate reference
//               tick     out one-cycle pulse per baud_clk rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tick_detect (
    input  logic clock,
    input  logic reset,
    input  logic baud_clk,
    output logic tick
);

    logic r_baud_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_baud_prev <= 1'b0;
        end else begin
            r_baud_prev <= baud_clk;
        end
    end

    assign tick = baud_clk & ~r_baud_prev;

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : UART transmitter. Serialises one byte per accepted request
//               into start bit, 8 data bits LSB first, optional parity bit
//               and 1 or 2 stop bits. Bit timing follows rising edges of
//               baud_clk; tx_out is registered so every bit change lands one
//               clock after a tick.
// Macro       : UART_TX_PARITY_EN - when defined, a parity bit (even/odd per
//               parity_odd) follows the data bits; otherwise parity_odd is
//               unused and DATA proceeds straight to STOP.
// Ports       : clock      in  system clock
//               reset      in  asynchronous active-high reset
//               baud_clk   in  bit-rate reference (rising edge = bit tick)
//               data_in    in  byte to send, latched on acceptance
//               send       in  transmit request
//               stop2      in  1 = two stop bits, latched on acceptance
//               parity_odd in  1 = odd parity, latched on acceptance
//               ready      out idle and able to accept a request
//               busy       out frame in progress
//               done       out one-cycle pulse on the first idle cycle
//               tx_out     out serial line, idles high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 send,
    input  logic                 stop2,
    input  logic                 parity_odd,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 tx_out
);

    localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t              r_state;
    tx_state_t              w_state_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic [2:0]             r_cnt;
    logic [2:0]             w_cnt_next;
    logic                   r_stop2;
    logic                   w_stop2_next;
    logic                   r_stop_cnt;
    logic                   w_stop_cnt_next;
    logic                   r_tx;
    logic                   w_tx_next;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_tick;

`ifdef UART_TX_PARITY_EN
    // Parity is resolved at acceptance since the shift register is consumed
    // by the time the parity bit goes out.
    logic                   r_par_bit;
    logic                   w_par_bit_next;
`else
    logic                   w_unused_parity_odd;
    assign w_unused_parity_odd = parity_odd;
`endif

    uart_tick_detect u_tick_detect (
        .clock    (clock),
        .reset    (reset),
        .baud_clk (baud_clk),
        .tick     (w_tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_cnt      <= 3'd0;
            r_stop2    <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_bit  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_cnt      <= w_cnt_next;
            r_stop2    <= w_stop2_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_tx       <= w_tx_next;
            r_busy     <= (w_state_next != IDLE);
            r_done     <= (r_state == STOP) && (w_state_next == IDLE);
`ifdef UART_TX_PARITY_EN
            r_par_bit  <= w_par_bit_next;
`endif
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_cnt_next      = r_cnt;
        w_stop2_next    = r_stop2;
        w_stop_cnt_next = r_stop_cnt;
        w_tx_next       = 1'b1;
`ifdef UART_TX_PARITY_EN
        w_par_bit_next  = r_par_bit;
`endif

        case (r_state)
            IDLE: begin
                // A tick coincident with acceptance is deliberately ignored;
                // ARM then waits for the next tick so START is a full period.
                if (send) begin
                    w_state_next = ARM;
                    w_shift_next = data_in;
                    w_stop2_next = stop2;
`ifdef UART_TX_PARITY_EN
                    w_par_bit_next = (^data_in) ^ (parity_odd == PARITY_ODD);
`endif
                end
            end
            ARM: begin
                if (w_tick) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                    w_cnt_next   = 3'd0;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
                    w_cnt_next   = r_cnt + 3'd1;
                    if (r_cnt == c_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next    = STOP;
                        w_stop_cnt_next = 1'b0;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_next    = STOP;
                    w_stop_cnt_next = 1'b0;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    if (r_stop2 && !r_stop_cnt) begin
                        w_stop_cnt_next = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Line level is a function of where the FSM will be next cycle, so
        // the registered output moves in step with the state.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = r_par_bit;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    assign ready  = (r_state == IDLE);
    assign busy   = r_busy;
    assign done   = r_done;
    assign tx_out = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Self-checking bench for uart_tx_frame. A frame is modelled as
//               a list of line levels (start, data LSB first, optional
//               parity, stop bits); bit k of the list is expected on tx_out
//               between the k-th and (k+1)-th baud tick after acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clock;
    logic       reset;
    logic       baud_clk;
    logic [7:0] data_in;
    logic       send;
    logic       stop2;
    logic       parity_odd;
    logic       ready;
    logic       busy;
    logic       done;
    logic       tx_out;

    logic       tb_tick;
    int         checks;
    int         errors;

    uart_tx_frame #(.DATA_BITS(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .baud_clk   (baud_clk),
        .data_in    (data_in),
        .send       (send),
        .stop2      (stop2),
        .parity_odd (parity_odd),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .tx_out     (tx_out)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    // Baud reference: 8-clock period, 4 high / 4 low, updated just after
    // each rising clock edge. tb_tick marks cycles holding a rising edge.
    initial begin
        int phase;
        logic nb;
        phase    = 0;
        baud_clk = 1'b0;
        tb_tick  = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            phase    = (phase + 1) % 8;
            nb       = (phase < 4);
            tb_tick  = nb & ~baud_clk;
            baud_clk = nb;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Request a frame: wait for ready (optionally also for a tick cycle),
    // assert send for exactly one accepting edge, then scramble the inputs.
    task automatic request(input logic [7:0] d, input bit s2, input bit po, input bit on_tick);
        int guard;
        guard = 0;
        @(negedge clock);
        while ((!ready || (on_tick && !tb_tick)) && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL request_wait: ready=%b required 1", ready);
        end
        data_in    = d;
        stop2      = s2;
        parity_odd = po;
        send       = 1'b1;
        @(posedge clock);
        #1;
        send       = 1'b0;
        data_in    = 8'($urandom);
        stop2      = 1'($urandom);
        parity_odd = 1'($urandom);
    endtask

    // Follow one frame from the cycle after acceptance to its done cycle.
    // mode 0 plain, 2 pulse send mid-DATA, 3 reset during bit 3,
    // 4 issue the next request (nd/ns2/npo) in the done cycle.
    task automatic monitor_frame(input logic [7:0] d, input bit s2, input bit po, input int mode,
                                 input logic [7:0] nd, input bit ns2, input bit npo,
                                 output int start_idx, output int stop_len,
                                 output int par_seen, output int dones);
        bit   q[$];
        int   k, n, nbits;
        bit   injected;
        logic exp_tx, exp_done, exp_busy;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (P == 1) q.push_back((^d) ^ po);
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        nbits     = q.size();
        k         = 0;
        n         = 0;
        injected  = 1'b0;
        start_idx = -1;
        stop_len  = 0;
        par_seen  = -1;
        dones     = 0;
        while (n < 400) begin
            @(negedge clock);
            n++;
            send     = 1'b0;
            exp_tx   = (k == 0 || k > nbits) ? 1'b1 : q[k-1];
            exp_done = (k == nbits + 1);
            exp_busy = (k <= nbits);
            checks += 4;
            if (tx_out !== exp_tx) begin
                errors++;
                $display("FAIL tx_bit: tick=%0d cycle=%0d tx_out=%b required %b", k, n, tx_out, exp_tx);
            end
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done_pulse: tick=%0d done=%b required %b", k, done, exp_done);
            end
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy_level: tick=%0d busy=%b required %b", k, busy, exp_busy);
            end
            if (ready !== !exp_busy) begin
                errors++;
                $display("FAIL ready_level: tick=%0d ready=%b required %b", k, ready, !exp_busy);
            end
            if (done === 1'b1) dones++;
            if (tx_out === 1'b0 && start_idx < 0) start_idx = n;
            if (P == 1 && k == 10) par_seen = int'(tx_out);
            if (k > 9 + P && k <= nbits) stop_len++;
            if (k == nbits + 1) begin
                if (mode == 4) begin
                    data_in    = nd;
                    stop2      = ns2;
                    parity_odd = npo;
                    send       = 1'b1;
                    @(posedge clock);
                    #1;
                    send       = 1'b0;
                    data_in    = 8'($urandom);
                end
                return;
            end
            if (mode == 2 && k == 4 && !injected) begin
                data_in  = 8'h00;
                send     = 1'b1;
                injected = 1'b1;
            end else begin
                data_in = 8'($urandom);
            end
            if (mode == 3 && k == 5) begin
                #2 reset = 1'b1;
                #1;
                checks += 4;
                if (tx_out !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_tx: tx_out=%b required 1", tx_out);
                end
                if (ready !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_ready: ready=%b required 1", ready);
                end
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_busy: busy=%b required 0", busy);
                end
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_done: done=%b required 0", done);
                end
                repeat (2) begin
                    @(negedge clock);
                    checks++;
                    if (done !== 1'b0 || tx_out !== 1'b1) begin
                        errors++;
                        $display("FAIL reset_hold: done=%b tx_out=%b required 0/1", done, tx_out);
                    end
                end
                reset = 1'b0;
                return;
            end
            if (tb_tick) k++;
        end
        checks++;
        errors++;
        $display("FAIL frame_timeout: ticks=%0d required %0d", k, nbits + 1);
    endtask

    // One cycle after a finished frame: done has dropped and the block idles.
    task automatic after_frame();
        @(negedge clock);
        checks += 2;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b required 0", done);
        end
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            errors++;
            $display("FAIL post_idle: busy=%b tx_out=%b required 0/1", busy, tx_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks += 4;
        if (tx_out !== 1'b1) begin errors++; $display("FAIL rst_tx: tx_out=%b required 1", tx_out); end
        if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: ready=%b required 1", ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: busy=%b required 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: done=%b required 0", done); end
        reset = 1'b0;
    endtask

    task automatic test_basic_a5();
        int si, sl, ps, dn;
        request(8'hA5, 1'b0, 1'b0, 1'b0);
        monitor_frame(8'hA5, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, si, sl, ps, dn);
        checks += 2;
        if (sl !== 8) begin errors++; $display("FAIL a5_stop_len: cycles=%0d required 8", sl); end
        if (dn !== 1) begin errors++; $display("FAIL a5_done_count: dones=%0d required 1", dn); end
        after_frame();
    endtask

    task automatic test_parity();
        int si, sl, ps, dn;
        request(8'hA5, 1'b0, 1'b0, 1'b0);
        monitor_frame(8'hA5, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, si, sl, ps, dn);
`ifdef UART_TX_PARITY_EN
        checks++;
        if (ps !== 0) begin errors++; $display("FAIL par_a5_even: parity=%0d required 0", ps); end
`endif
        request(8'hA5, 1'b0, 1'b1, 1'b0);
        monitor_frame(8'hA5, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, si, sl, ps, dn);
`ifdef UART_TX_PARITY_EN
        checks++;
        if (ps !== 1) begin errors++; $display("FAIL par_a5_odd: parity=%0d required 1", ps); end
`endif
        request(8'h01, 1'b0, 1'b0, 1'b0);
        monitor_frame(8'h01, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, si, sl, ps, dn);
`ifdef UART_TX_PARITY_EN
        checks++;
        if (ps !== 1) begin errors++; $display("FAIL par_01_even: parity=%0d required 1", ps); end
`endif
        after_frame();
    endtask

    task automatic test_stop2_back_to_back();
        int si, sl, ps, dn;
        request(8'hFF, 1'b1, 1'b0, 1'b0);
        monitor_frame(8'hFF, 1'b1, 1'b0, 4, 8'h3C, 1'b0, 1'b1, si, sl, ps, dn);
        checks++;
        if (sl !== 16) begin errors++; $display("FAIL stop2_len: cycles=%0d required 16", sl); end
        monitor_frame(8'h3C, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, si, sl, ps, dn);
        checks++;
        if (si < 2 || si > 9) begin errors++; $display("FAIL b2b_start: cycle=%0d required 2..9", si); end
        after_frame();
    endtask

    task automatic test_send_ignored();
        int si, sl, ps, dn;
        request(8'h96, 1'b0, 1'b1, 1'b0);
        monitor_frame(8'h96, 1'b0, 1'b1, 2, 8'h00, 1'b0, 1'b0, si, sl, ps, dn);
        checks++;
        if (dn !== 1) begin errors++; $display("FAIL ignored_done_count: dones=%0d required 1", dn); end
        after_frame();
    endtask

    task automatic test_tick_coincident();
        int si, sl, ps, dn;
        request(8'h5A, 1'b0, 1'b0, 1'b1);
        monitor_frame(8'h5A, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, si, sl, ps, dn);
        checks++;
        if (si !== 9) begin errors++; $display("FAIL coincident_start: cycle=%0d required 9", si); end
        after_frame();
    endtask

    task automatic test_reset_mid_frame();
        int si, sl, ps, dn;
        request(8'hC3, 1'b1, 1'b0, 1'b0);
        monitor_frame(8'hC3, 1'b1, 1'b0, 3, 8'h00, 1'b0, 1'b0, si, sl, ps, dn);
        request(8'h00, 1'b0, 1'b0, 1'b0);
        monitor_frame(8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, si, sl, ps, dn);
        checks++;
        if (dn !== 1) begin errors++; $display("FAIL post_reset_done: dones=%0d required 1", dn); end
        after_frame();
    endtask

    task automatic test_random();
        int si, sl, ps, dn;
        logic [7:0] d;
        bit s2, po, tk;
        for (int i = 0; i < 12; i++) begin
            d  = 8'($urandom);
            s2 = 1'($urandom);
            po = 1'($urandom);
            tk = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 10)) @(negedge clock);
            request(d, s2, po, tk);
            monitor_frame(d, s2, po, 0, 8'h00, 1'b0, 1'b0, si, sl, ps, dn);
            checks++;
            if (sl !== (s2 ? 16 : 8)) begin
                errors++;
                $display("FAIL rand_stop_len: frame=%0d cycles=%0d required %0d", i, sl, s2 ? 16 : 8);
            end
        end
        after_frame();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        send       = 1'b0;
        data_in    = 8'h00;
        stop2      = 1'b0;
        parity_odd = 1'b0;
        test_reset();
        test_basic_a5();
        test_parity();
        test_stop2_back_to_back();
        test_send_ignored();
        test_tick_coincident();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
